// File: rtl/watch_mode_ctrl.sv
// Watch sequencer: mode FSM, hh:mm:ss timekeeping, alarm registers and ring timer.
// Every output is registered and reflects the state produced by the most recent clock edge.
module watch_mode_ctrl #(
  parameter int unsigned RING_SECS    = 60,
  parameter int unsigned ALARM_HR_DEF = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       key_stb,
  input  logic [2:0] key_code,
  output logic [2:0] mode,
  output logic [4:0] disp_hr,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic       blink,
  output logic       alarm_en,
  output logic       alarm_ring
);

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StSetHr  = 3'd1,
    StSetMin = 3'd2,
    StAlmHr  = 3'd3,
    StAlmMin = 3'd4
  } state_e;

  localparam logic [2:0] KeyMode    = 3'd0;
  localparam logic [2:0] KeyUp      = 3'd1;
  localparam logic [2:0] KeyDown    = 3'd2;
  localparam logic [2:0] KeyAlm     = 3'd3;
  localparam logic [4:0] AlarmHrRst = 5'(ALARM_HR_DEF);
  localparam logic [7:0] RingLast   = 8'(RING_SECS - 1);

  state_e     state_q, state_d;
  logic [4:0] hr_q, hr_d, alm_hr_q, alm_hr_d;
  logic [5:0] min_q, min_d, sec_q, sec_d, alm_min_q, alm_min_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       alm_en_q, alm_en_d, ring_q, ring_d, blink_q, blink_d;
  logic       key_mode, key_up, key_down, key_alm, time_runs, trigger, alm_view;

  // Modular increment/decrement over 0..top.
  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] top,
                                          input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  always_comb begin
    key_mode   = key_stb && (key_code == KeyMode);
    key_up     = key_stb && (key_code == KeyUp);
    key_down   = key_stb && (key_code == KeyDown);
    key_alm    = key_stb && (key_code == KeyAlm);
    time_runs  = (state_q != StSetHr) && (state_q != StSetMin);

    state_d    = state_q;
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    alm_hr_d   = alm_hr_q;
    alm_min_d  = alm_min_q;
    alm_en_d   = alm_en_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    blink_d    = blink_q;

    if (tick_1hz && time_runs) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // Evaluated on the post-tick time, before any key edit clears or alters it.
    trigger = tick_1hz && time_runs && alm_en_q && (sec_d == 6'd0) &&
              (hr_d == alm_hr_q) && (min_d == alm_min_q);

    if (key_mode) begin
      unique case (state_q)
        StRun: begin
          state_d = StSetHr;
          sec_d   = 6'd0;
        end
        StSetHr:  state_d = StSetMin;
        StSetMin: state_d = StAlmHr;
        StAlmHr:  state_d = StAlmMin;
        default:  state_d = StRun;
      endcase
    end

    if (key_up || key_down) begin
      unique case (state_q)
        StSetHr:  hr_d      = 5'(step_mod({1'b0, hr_d}, 6'd23, key_up));
        StSetMin: min_d     = step_mod(min_d, 6'd59, key_up);
        StAlmHr:  alm_hr_d  = 5'(step_mod({1'b0, alm_hr_q}, 6'd23, key_up));
        StAlmMin: alm_min_d = step_mod(alm_min_q, 6'd59, key_up);
        default:  ;
      endcase
    end

    if (ring_q && tick_1hz) begin
      if (ring_cnt_q == RingLast) begin
        ring_d     = 1'b0;
        ring_cnt_d = 8'd0;
      end else begin
        ring_cnt_d = ring_cnt_q + 8'd1;
      end
    end
    if (trigger) begin
      ring_d     = 1'b1;
      ring_cnt_d = 8'd0;
    end

    // A ringing alarm turns ALM into a pure acknowledge.
    if (key_alm) begin
      if (ring_q) begin
        ring_d     = 1'b0;
        ring_cnt_d = 8'd0;
      end else if (state_q == StRun) begin
        alm_en_d = ~alm_en_q;
      end
    end
    if (!alm_en_d) begin
      ring_d     = 1'b0;
      ring_cnt_d = 8'd0;
    end

    if (state_d == StRun) begin
      blink_d = 1'b0;
    end else if ((state_d != state_q) || key_up || key_down) begin
      blink_d = 1'b1;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end

    alm_view = (state_d == StAlmHr) || (state_d == StAlmMin);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      hr_q       <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      alm_hr_q   <= AlarmHrRst;
      alm_min_q  <= 6'd0;
      alm_en_q   <= 1'b0;
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
      blink_q    <= 1'b0;
      disp_hr    <= 5'd0;
      disp_min   <= 6'd0;
    end else begin
      state_q    <= state_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      alm_en_q   <= alm_en_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      blink_q    <= blink_d;
      disp_hr    <= alm_view ? alm_hr_d : hr_d;
      disp_min   <= alm_view ? alm_min_d : min_d;
    end
  end

  assign mode       = state_q;
  assign disp_sec   = sec_q;
  assign blink      = blink_q;
  assign alarm_en   = alm_en_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_watch_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_stb = 1'b0;
  logic [2:0] key_code = 3'd0;
  logic [2:0] mode;
  logic [4:0] disp_hr;
  logic [5:0] disp_min, disp_sec;
  logic       blink, alarm_en, alarm_ring;

  localparam logic [2:0] KMode = 3'd0, KUp = 3'd1, KDown = 3'd2, KAlm = 3'd3;

  typedef struct {
    string      name;
    logic [22:0] vec;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  watch_mode_ctrl #(
    .RING_SECS   (60),
    .ALARM_HR_DEF(7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .key_stb   (key_stb),
    .key_code  (key_code),
    .mode      (mode),
    .disp_hr   (disp_hr),
    .disp_min  (disp_min),
    .disp_sec  (disp_sec),
    .blink     (blink),
    .alarm_en  (alarm_en),
    .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic t, input logic k, input logic [2:0] c);
    #1;
    rst_n    = r;
    tick_1hz = t;
    key_stb  = k;
    key_code = c;
    @(posedge clk);
  endtask

  task automatic tick();
    step(1'b1, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic key(input logic [2:0] c);
    step(1'b1, 1'b0, 1'b1, c);
  endtask

  // Called right after a step: the monitor compares at the following negedge.
  task automatic chk(input string name, input int m, input int h, input int mi, input int s,
                     input int b, input int en, input int rg);
    exp_t e;
    e.name = name;
    e.vec  = {3'(m), 5'(h), 6'(mi), 6'(s), 1'(b), 1'(en), 1'(rg)};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checks++;
      if ({mode, disp_hr, disp_min, disp_sec, blink, alarm_en, alarm_ring} !== cur.vec) begin
        errors++;
        $display("FAIL %s: got mode=%0d hr=%0d min=%0d sec=%0d blink=%0d en=%0d ring=%0d, want mode=%0d hr=%0d min=%0d sec=%0d blink=%0d en=%0d ring=%0d",
                 cur.name, mode, disp_hr, disp_min, disp_sec, blink, alarm_en, alarm_ring,
                 cur.vec[22:20], cur.vec[19:15], cur.vec[14:9], cur.vec[8:3],
                 cur.vec[2], cur.vec[1], cur.vec[0]);
      end
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("run_count", 0, 0, 0, 3, 0, 0, 0);

    // Time edit
    key(KMode);          chk("enter_set_hr", 1, 0, 0, 0, 1, 0, 0);
    key(KDown);          chk("hr_dec_wrap", 1, 23, 0, 0, 1, 0, 0);
    tick();              chk("set_frozen", 1, 23, 0, 0, 0, 0, 0);
    key(KMode);          chk("enter_set_min", 2, 23, 0, 0, 1, 0, 0);
    repeat (59) key(KUp);
    chk("min_59", 2, 23, 59, 0, 1, 0, 0);
    key(KUp);            chk("min_wrap", 2, 23, 0, 0, 1, 0, 0);
    step(1'b1, 1'b1, 1'b1, KUp);
    chk("collide_set", 2, 23, 1, 0, 1, 0, 0);
    repeat (2) key(KDown);
    chk("min_dec_wrap", 2, 23, 59, 0, 1, 0, 0);

    // Alarm edit to 00:01; time keeps counting in ALM states
    key(KMode);          chk("enter_alm_hr", 3, 7, 0, 0, 1, 0, 0);
    repeat (17) key(KUp);
    chk("alm_hr_wrap", 3, 0, 0, 0, 1, 0, 0);
    key(KMode);
    key(KUp);            chk("alm_min_set", 4, 0, 1, 0, 1, 0, 0);
    repeat (59) tick();
    chk("alm_counts", 4, 0, 1, 59, 0, 0, 0);
    key(KMode);          chk("back_run", 0, 23, 59, 59, 0, 0, 0);
    tick();              chk("rollover", 0, 0, 0, 0, 0, 0, 0);

    // Alarm ring in RUN and timed self-clear
    key(KAlm);           chk("alm_en", 0, 0, 0, 0, 0, 1, 0);
    repeat (59) tick();
    chk("pre_ring", 0, 0, 0, 59, 0, 1, 0);
    tick();              chk("ring_on", 0, 0, 1, 0, 0, 1, 1);
    repeat (59) tick();
    chk("ring_hold", 0, 0, 1, 59, 0, 1, 1);
    tick();              chk("ring_off", 0, 0, 2, 0, 0, 1, 0);

    // Ring while in ALM_MIN, then acknowledge
    repeat (4) key(KMode);
    repeat (2) key(KUp);
    chk("alm_min_3", 4, 0, 3, 0, 1, 1, 0);
    repeat (60) tick();
    chk("ring_alm_state", 4, 0, 3, 0, 1, 1, 1);
    key(KAlm);           chk("ack_alm", 4, 0, 3, 0, 1, 1, 0);
    key(KAlm);           chk("alm_ignored", 4, 0, 3, 0, 1, 1, 0);
    key(KMode);          chk("run_again", 0, 0, 3, 0, 0, 1, 0);
    step(1'b1, 1'b1, 1'b1, KUp);
    chk("collide_run", 0, 0, 3, 1, 0, 1, 0);
    key(3'd5);           chk("code_ignored", 0, 0, 3, 1, 0, 1, 0);

    // Reset while ringing in ALM_MIN
    repeat (4) key(KMode);
    key(KUp);
    repeat (60) tick();
    chk("ring2", 4, 0, 4, 0, 1, 1, 1);
    step(1'b0, 1'b0, 1'b0, 3'd0);
    chk("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) key(KMode);
    chk("reset_alarm", 3, 7, 0, 0, 1, 0, 0);

    repeat (3) step(1'b1, 1'b0, 1'b0, 3'd0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
